// File: rtl/pipe_fetch_decode_skid_pkg.sv
// ---------------------------------------------------------------------------
// pipe_fd_pkg
// Shared definitions for the IF/ID skid-buffered pipeline register:
//   - default bundle geometry (FD_XLEN, FD_LANES)
//   - NOP_INSTR: encoding driven on squashed lanes (MIPS sll $0,$0,0)
//   - fd_count_e: occupancy states of the two-entry buffer
//   - fd_bundle_t: one fetch bundle at the default geometry
//   - squash_lanes(): replaces invalid lanes of a bundle with NOP
// ---------------------------------------------------------------------------
package pipe_fd_pkg;

    localparam int          FD_XLEN   = 32;
    localparam int          FD_LANES  = 2;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        CNT0 = 2'd0,
        CNT1 = 2'd1,
        CNT2 = 2'd2
    } fd_count_e;

    typedef struct packed {
        logic [FD_XLEN-1:0]                pc;
        logic [FD_XLEN-1:0]                pcplus4;
        logic [FD_LANES-1:0][FD_XLEN-1:0]  instr;
        logic [FD_LANES-1:0]               lane_valid;
    } fd_bundle_t;

    // A lane survives only if the bundle itself is valid and the lane is valid.
    function automatic fd_bundle_t squash_lanes(input fd_bundle_t b, input logic vld);
        fd_bundle_t r;
        r = b;
        for (int i = 0; i < FD_LANES; i++) begin
            if (!(vld && b.lane_valid[i])) begin
                r.instr[i] = NOP_INSTR;
            end
        end
        if (!vld) begin
            r.lane_valid = '0;
        end
        return r;
    endfunction

endpackage

// File: rtl/pipe_fetch_decode_skid_if.sv
// ---------------------------------------------------------------------------
// pipe_fd_if
// Valid/ready bundle link between pipeline stages.
//   valid       bundle present (master -> slave)
//   ready       slave can take the bundle (slave -> master)
//   pc, pcplus4 PC of lane 0 and PC+4
//   instr       LANES instruction words, lane i at [i*XLEN +: XLEN]
//   lane_valid  per-lane valid, lane 0 oldest
// ---------------------------------------------------------------------------
interface pipe_fd_if #(
    parameter int XLEN  = 32,
    parameter int LANES = 2
);
    logic                  valid;
    logic                  ready;
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       pcplus4;
    logic [LANES*XLEN-1:0] instr;
    logic [LANES-1:0]      lane_valid;

    modport master (
        output valid, pc, pcplus4, instr, lane_valid,
        input  ready
    );

    modport slave (
        input  valid, pc, pcplus4, instr, lane_valid,
        output ready
    );
endinterface

// File: rtl/pipe_fetch_decode_skid_slot.sv
// ---------------------------------------------------------------------------
// pipe_fd_slot
// One bundle register of the skid buffer.
//   clk            system clock
//   clr            synchronous clear of the lane-valid bits (wins over ld)
//   ld             load the *_in bundle
//   pc_in ..       incoming bundle fields
//   pc_o ..        stored bundle fields
// Only lane_valid is cleared; PC and instruction words are plain data whose
// contents are masked by the top whenever the slot is not occupied.
// ---------------------------------------------------------------------------
module pipe_fd_slot #(
    parameter int XLEN  = 32,
    parameter int LANES = 2
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  ld,
    input  logic [XLEN-1:0]       pc_in,
    input  logic [XLEN-1:0]       pcplus4_in,
    input  logic [LANES*XLEN-1:0] instr_in,
    input  logic [LANES-1:0]      lane_valid_in,
    output logic [XLEN-1:0]       pc_o,
    output logic [XLEN-1:0]       pcplus4_o,
    output logic [LANES*XLEN-1:0] instr_o,
    output logic [LANES-1:0]      lane_valid_o
);

    logic [XLEN-1:0]       pc_q,         pc_d;
    logic [XLEN-1:0]       pcplus4_q,    pcplus4_d;
    logic [LANES*XLEN-1:0] instr_q,      instr_d;
    logic [LANES-1:0]      lane_valid_q, lane_valid_d;

    always_comb begin
        pc_d         = pc_q;
        pcplus4_d    = pcplus4_q;
        instr_d      = instr_q;
        lane_valid_d = lane_valid_q;
        if (ld) begin
            pc_d         = pc_in;
            pcplus4_d    = pcplus4_in;
            instr_d      = instr_in;
            lane_valid_d = lane_valid_in;
        end
        if (clr) begin
            lane_valid_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        pc_q         <= pc_d;
        pcplus4_q    <= pcplus4_d;
        instr_q      <= instr_d;
        lane_valid_q <= lane_valid_d;
    end

    assign pc_o         = pc_q;
    assign pcplus4_o    = pcplus4_q;
    assign instr_o      = instr_q;
    assign lane_valid_o = lane_valid_q;

endmodule

// File: rtl/pipe_fetch_decode_skid.sv
// ---------------------------------------------------------------------------
// pipe_fetch_decode_skid
// IF/ID pipeline register with a two-entry skid buffer for an N-issue fetch
// front end.
//   clk    system clock, all state on posedge
//   rst    synchronous active-high reset (wins over flush)
//   flush  redirect: empties the buffer and drops the incoming bundle
//   f      slave side of the fetch link (f.ready depends on state only)
//   d      master side of the decode link (d.ready = 0 is a decode stall)
// E0 is the head and drives d.*; E1 holds the bundle that arrives while
// decode is stalled, so f.ready never depends on d.ready combinationally.
// ---------------------------------------------------------------------------
module pipe_fetch_decode_skid
    import pipe_fd_pkg::*;
#(
    parameter int              XLEN  = FD_XLEN,
    parameter int              LANES = FD_LANES,
    parameter logic [XLEN-1:0] NOP   = XLEN'(NOP_INSTR)
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      flush,
    pipe_fd_if.slave  f,
    pipe_fd_if.master d
);

    fd_count_e state_q, state_d;

    logic f_ready;
    logic d_valid;
    logic accept;
    logic pop;
    logic e0_ld;
    logic e1_ld;
    logic e0_from_skid;
    logic slot_clr;

    logic [XLEN-1:0]       e0_pc,  e1_pc;
    logic [XLEN-1:0]       e0_pc4, e1_pc4;
    logic [LANES*XLEN-1:0] e0_instr, e1_instr;
    logic [LANES-1:0]      e0_lv,  e1_lv;

    logic [XLEN-1:0]       e0_pc_in;
    logic [XLEN-1:0]       e0_pc4_in;
    logic [LANES*XLEN-1:0] e0_instr_in;
    logic [LANES-1:0]      e0_lv_in;

    // Occupancy FSM: next state and slot enables.
    always_comb begin
        f_ready      = (state_q != CNT2);
        d_valid      = (state_q != CNT0);
        accept       = f.valid & f_ready & ~flush;
        pop          = d_valid & d.ready;
        state_d      = state_q;
        e0_ld        = 1'b0;
        e1_ld        = 1'b0;
        e0_from_skid = 1'b0;
        if (flush) begin
            state_d = CNT0;
        end else begin
            unique case (state_q)
                CNT0: begin
                    if (accept) begin
                        e0_ld   = 1'b1;
                        state_d = CNT1;
                    end
                end
                CNT1: begin
                    if (accept && pop) begin
                        e0_ld = 1'b1;
                    end else if (accept) begin
                        e1_ld   = 1'b1;
                        state_d = CNT2;
                    end else if (pop) begin
                        state_d = CNT0;
                    end
                end
                CNT2: begin
                    // f_ready is low here, so only the skid entry can advance.
                    if (pop) begin
                        e0_ld        = 1'b1;
                        e0_from_skid = 1'b1;
                        state_d      = CNT1;
                    end
                end
                default: state_d = CNT0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CNT0;
        end else begin
            state_q <= state_d;
        end
    end

    assign slot_clr = rst | flush;

    always_comb begin
        e0_pc_in    = f.pc;
        e0_pc4_in   = f.pcplus4;
        e0_instr_in = f.instr;
        e0_lv_in    = f.lane_valid;
        if (e0_from_skid) begin
            e0_pc_in    = e1_pc;
            e0_pc4_in   = e1_pc4;
            e0_instr_in = e1_instr;
            e0_lv_in    = e1_lv;
        end
    end

    pipe_fd_slot #(.XLEN(XLEN), .LANES(LANES)) u_e0 (
        .clk           (clk),
        .clr           (slot_clr),
        .ld            (e0_ld),
        .pc_in         (e0_pc_in),
        .pcplus4_in    (e0_pc4_in),
        .instr_in      (e0_instr_in),
        .lane_valid_in (e0_lv_in),
        .pc_o          (e0_pc),
        .pcplus4_o     (e0_pc4),
        .instr_o       (e0_instr),
        .lane_valid_o  (e0_lv)
    );

    pipe_fd_slot #(.XLEN(XLEN), .LANES(LANES)) u_e1 (
        .clk           (clk),
        .clr           (slot_clr),
        .ld            (e1_ld),
        .pc_in         (f.pc),
        .pcplus4_in    (f.pcplus4),
        .instr_in      (f.instr),
        .lane_valid_in (f.lane_valid),
        .pc_o          (e1_pc),
        .pcplus4_o     (e1_pc4),
        .instr_o       (e1_instr),
        .lane_valid_o  (e1_lv)
    );

    assign f.ready = f_ready;

    // Head outputs are masked by occupancy so stale slot data never leaks.
    always_comb begin
        d.valid      = d_valid;
        d.pc         = d_valid ? e0_pc  : '0;
        d.pcplus4    = d_valid ? e0_pc4 : '0;
        d.lane_valid = d_valid ? e0_lv  : '0;
        d.instr      = '0;
        for (int i = 0; i < LANES; i++) begin
            d.instr[i*XLEN +: XLEN] = (d_valid && e0_lv[i]) ? e0_instr[i*XLEN +: XLEN] : NOP;
        end
    end

endmodule

// File: tb/tb_pipe_fetch_decode_skid.sv
module tb_pipe_fetch_decode_skid;

    logic clk;
    logic rst;
    logic flush;

    pipe_fd_if #(.XLEN(32), .LANES(2)) fi ();
    pipe_fd_if #(.XLEN(32), .LANES(2)) di ();

    pipe_fetch_decode_skid #(.XLEN(32), .LANES(2), .NOP(32'h0)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .f     (fi),
        .d     (di)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: a FIFO of capacity two ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [63:0] instr;
        logic [1:0]  lv;
    } bun_t;

    bun_t mq[$];
    bit   model_live = 0;

    always @(posedge clk) begin
        bit   acc;
        bit   pp;
        bun_t b;
        if (rst || flush) begin
            mq.delete();
        end else begin
            acc = fi.valid && (mq.size() < 2);
            pp  = (mq.size() > 0) && di.ready;
            b.pc    = fi.pc;
            b.pc4   = fi.pcplus4;
            b.instr = fi.instr;
            b.lv    = fi.lane_valid;
            if (pp)  void'(mq.pop_front());
            if (acc) mq.push_back(b);
        end
        model_live = 1;
    end

    always @(negedge clk) begin
        logic [63:0] ei;
        logic [31:0] epc, epc4;
        logic [1:0]  elv;
        bit          ev;
        if (model_live) begin
            ev   = (mq.size() > 0);
            epc  = ev ? mq[0].pc  : 32'h0;
            epc4 = ev ? mq[0].pc4 : 32'h0;
            elv  = ev ? mq[0].lv  : 2'b00;
            ei   = 64'h0;
            for (int i = 0; i < 2; i++) begin
                if (ev && mq[0].lv[i]) ei[i*32 +: 32] = mq[0].instr[i*32 +: 32];
            end
            check("m_d_valid",      {63'h0, di.valid},   {63'h0, ev});
            check("m_f_ready",      {63'h0, fi.ready},   {63'h0, (mq.size() < 2)});
            check("m_d_pc",         {32'h0, di.pc},      {32'h0, epc});
            check("m_d_pcplus4",    {32'h0, di.pcplus4}, {32'h0, epc4});
            check("m_d_instr",      di.instr,            ei);
            check("m_d_lane_valid", {62'h0, di.lane_valid}, {62'h0, elv});
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input bit v, input logic [31:0] pc, input logic [1:0] lv, input logic [63:0] ins);
        fi.valid      = v;
        fi.pc         = pc;
        fi.pcplus4    = pc + 32'd4;
        fi.lane_valid = lv;
        fi.instr      = ins;
    endtask

    initial begin
        rst      = 1'b1;
        flush    = 1'b0;
        di.ready = 1'b0;
        drv(1'b0, 32'h0, 2'b00, 64'h0);

        // 1: reset
        step();
        step();
        check("rst_d_valid", {63'h0, di.valid}, 64'h0);
        check("rst_d_instr", di.instr, 64'h0);
        check("rst_d_pc",    {32'h0, di.pc}, 64'h0);
        check("rst_f_ready", {63'h0, fi.ready}, 64'h1);
        rst = 1'b0;

        // 2: streaming, one per cycle, 1-cycle latency
        di.ready = 1'b1;
        drv(1'b1, 32'h100, 2'b11, 64'h1111_0001_1111_0000);
        step();
        check("str_pc0",    {32'h0, di.pc}, 64'h100);
        check("str_pc4_0",  {32'h0, di.pcplus4}, 64'h104);
        check("str_rdy0",   {63'h0, fi.ready}, 64'h1);
        drv(1'b1, 32'h108, 2'b11, 64'h2222_0001_2222_0000);
        step();
        check("str_pc1",    {32'h0, di.pc}, 64'h108);
        check("str_ins1",   di.instr, 64'h2222_0001_2222_0000);
        drv(1'b1, 32'h110, 2'b11, 64'h3333_0001_3333_0000);
        step();
        check("str_pc2",    {32'h0, di.pc}, 64'h110);
        check("str_rdy2",   {63'h0, fi.ready}, 64'h1);
        drv(1'b0, 32'h0, 2'b00, 64'h0);
        step();
        check("str_drain",  {63'h0, di.valid}, 64'h0);

        // 3: stall / skid
        di.ready = 1'b0;
        drv(1'b1, 32'h200, 2'b11, 64'hAAAA_0001_AAAA_0000);
        step();
        drv(1'b1, 32'h208, 2'b11, 64'hBBBB_0001_BBBB_0000);
        step();
        check("skid_full_rdy", {63'h0, fi.ready}, 64'h0);
        check("skid_hold_pc",  {32'h0, di.pc}, 64'h200);
        drv(1'b1, 32'h210, 2'b11, 64'hCCCC_0001_CCCC_0000);
        step();
        check("skid_hold_pc2", {32'h0, di.pc}, 64'h200);
        drv(1'b0, 32'h0, 2'b00, 64'h0);
        di.ready = 1'b1;
        step();
        check("skid_pc_next",  {32'h0, di.pc}, 64'h208);
        check("skid_rdy_back", {63'h0, fi.ready}, 64'h1);
        step();
        check("skid_empty",    {63'h0, di.valid}, 64'h0);

        // 4: flush under stall with a simultaneous input bundle
        di.ready = 1'b0;
        drv(1'b1, 32'h280, 2'b11, 64'h1);
        step();
        drv(1'b1, 32'h288, 2'b11, 64'h2);
        step();
        flush = 1'b1;
        drv(1'b1, 32'h300, 2'b11, 64'h3);
        step();
        check("fl_d_valid", {63'h0, di.valid}, 64'h0);
        check("fl_d_instr", di.instr, 64'h0);
        check("fl_f_ready", {63'h0, fi.ready}, 64'h1);
        flush = 1'b0;
        drv(1'b0, 32'h0, 2'b00, 64'h0);
        step();
        check("fl_no_300",  {63'h0, di.valid}, 64'h0);

        // 5: lane squash and bubble bundle
        di.ready = 1'b1;
        drv(1'b1, 32'h340, 2'b01, {32'h8C01_0004, 32'h2002_0001});
        step();
        check("sq_instr", di.instr, {32'h0000_0000, 32'h2002_0001});
        check("sq_lv",    {62'h0, di.lane_valid}, 64'h1);
        drv(1'b1, 32'h348, 2'b00, {32'h8C01_0004, 32'h2002_0001});
        step();
        check("bub_valid", {63'h0, di.valid}, 64'h1);
        check("bub_instr", di.instr, 64'h0);
        drv(1'b0, 32'h0, 2'b00, 64'h0);
        step();

        // 6: reset together with flush while full
        di.ready = 1'b0;
        drv(1'b1, 32'h400, 2'b11, 64'h4);
        step();
        drv(1'b1, 32'h408, 2'b11, 64'h5);
        step();
        rst   = 1'b1;
        flush = 1'b1;
        step();
        check("rf_d_valid", {63'h0, di.valid}, 64'h0);
        check("rf_d_pc",    {32'h0, di.pc}, 64'h0);
        check("rf_f_ready", {63'h0, fi.ready}, 64'h1);
        rst      = 1'b0;
        flush    = 1'b0;
        di.ready = 1'b1;
        drv(1'b1, 32'h500, 2'b10, 64'h5555_0001_5555_0000);
        step();
        check("rf_fresh_pc",  {32'h0, di.pc}, 64'h500);
        check("rf_fresh_ins", di.instr, 64'h5555_0001_0000_0000);
        drv(1'b0, 32'h0, 2'b00, 64'h0);
        step();

        // mixed traffic checked by the model every cycle
        for (int k = 0; k < 300; k++) begin
            drv(1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)), {$urandom, $urandom});
            di.ready = 1'($urandom_range(0, 2) != 0);
            flush    = ($urandom_range(0, 15) == 0);
            step();
        end
        flush = 1'b0;
        drv(1'b0, 32'h0, 2'b00, 64'h0);
        di.ready = 1'b1;
        step();
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
